uart_ctrl: RTL

Serial UART controller sitting directly downstream of the memory-mapped peripheral block: it consumes the peripheral's transmit byte and strobe and returns transmit status. It also delivers received bytes with a valid flag and accepts a read acknowledge. It converts between these parallel handshakes and the board's 8N1 serial pins (8 data bits, no parity, 1 stop bit), using 16x oversampled reception.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_ctrl_if.sv | 34 +++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: oversampling ratio and FSM state encodings.
// Latency: n/a (package only).
// Backpressure: n/a. Optional UART_PARITY_EN uses the *_PARITY states; otherwise they stay unused.
package uart_pkg;

  // Ticks per serial bit; RX samples mid-bit at the 8th tick after start detection.
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_ctrl_if.sv
// Parallel handshake bundle between the peripheral block (master) and the UART (slave).
// Latency: n/a (wires only).
// Backpressure: tx_status gates tx_en acceptance; rx_eff/rx_read form the receive handshake.
// Macro UART_PARITY_EN adds the rx_perr pulse.
interface uart_ctrl_if;
  logic [7:0] tx_data;     // byte to transmit, sampled on accept
  logic       tx_en;       // transmit strobe
  logic       tx_status;   // 1 = transmitter idle
  logic [7:0] rx_data;     // last committed received byte
  logic       rx_eff;      // rx_data valid and unread
  logic       rx_read;     // consumer acknowledge
  logic       rx_overrun;  // sticky: byte dropped while rx_eff was set
  logic       rx_ferr;     // one-cycle pulse: bad stop bit
`ifdef UART_PARITY_EN
  logic       rx_perr;     // one-cycle pulse: parity mismatch
`endif

  modport master (
    output tx_data, tx_en, rx_read,
`ifdef UART_PARITY_EN
    input  rx_perr,
`endif
    input  tx_status, rx_data, rx_eff, rx_overrun, rx_ferr
  );

  modport slave (
    input  tx_data, tx_en, rx_read,
`ifdef UART_PARITY_EN
    output rx_perr,
`endif
    output tx_status, rx_data, rx_eff, rx_overrun, rx_ferr
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: divides clk by DIV, one-cycle tick, synchronous restart.
// Latency: first tick DIV cycles after the restart cycle.
// Backpressure: none; free-running except for restart.
// Ports: clk, reset (async active-low), restart (sync phase clear), tick (1-cycle pulse).
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // No tick in the restart cycle so a restarted phase always counts a full DIV.
  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: parallel tx/rx handshakes <-> 8N1 serial pins, 16x oversampled RX.
// Latency: TX line low the edge after accept, frame 160*DIV cycles; rx_eff ~9.5 bits + 3 cycles after start edge.
// Backpressure: tx_en ignored while tx_status=0; RX drops and flags overrun when rx_eff still set.
// Ports: clk, reset (async active-low), bus (uart_ctrl_if.slave), uart_rx (async pin), uart_tx (idle high).
// Macro UART_PARITY_EN switches to 8E1 with TX_PARITY/RX_PARITY and the rx_perr pulse.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        uart_rx,
  output logic        uart_tx
);

  // Clock cycles per oversample tick; the parameters must give at least 1.
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  // ---------------- TX ----------------
  tx_state_t  tx_state, tx_state_n;
  logic [3:0] tx_tick_cnt, tx_tick_cnt_n;
  logic [2:0] tx_bit_idx, tx_bit_idx_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic       tx_line_n;
  logic       tx_restart, tx_tick;

  uart_baud_gen #(.DIV(DIV)) u_tx_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (tx_restart),
    .tick    (tx_tick)
  );

  assign bus.tx_status = (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n    = tx_state;
    tx_tick_cnt_n = tx_tick_cnt;
    tx_bit_idx_n  = tx_bit_idx;
    tx_byte_n     = tx_byte;
    tx_restart    = 1'b0;
    tx_line_n     = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (bus.tx_en) begin
          tx_byte_n     = bus.tx_data;
          tx_restart    = 1'b1;
          tx_tick_cnt_n = '0;
          tx_state_n    = TX_START;
        end
      end
      default: begin
        if (tx_tick) begin
          tx_tick_cnt_n = tx_tick_cnt + 4'd1;
          if (tx_tick_cnt == TICK_LAST) begin
            case (tx_state)
              TX_START: begin
                tx_state_n   = TX_DATA;
                tx_bit_idx_n = '0;
              end
              TX_DATA: begin
                tx_bit_idx_n = tx_bit_idx + 3'd1;
                if (tx_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  tx_state_n = TX_PARITY;
`else
                  tx_state_n = TX_STOP;
`endif
                end
              end
              TX_PARITY: tx_state_n = TX_STOP;
              default:   tx_state_n = TX_IDLE;
            endcase
          end
        end
      end
    endcase
    // The pin is registered from the next state so it changes on the same edge as the FSM.
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_byte_n[tx_bit_idx_n];
      TX_PARITY: tx_line_n = ^tx_byte_n;
      default:   tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_byte     <= '0;
      uart_tx     <= 1'b1;
    end else begin
      tx_state    <= tx_state_n;
      tx_tick_cnt <= tx_tick_cnt_n;
      tx_bit_idx  <= tx_bit_idx_n;
      tx_byte     <= tx_byte_n;
      uart_tx     <= tx_line_n;
    end
  end

  // ---------------- RX ----------------
  logic       rx_meta, rx_s;
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_tick_cnt, rx_tick_cnt_n;
  logic [2:0] rx_bit_idx, rx_bit_idx_n;
  logic [7:0] rx_shreg, rx_shreg_n;
  logic       rx_wait_hi, rx_wait_hi_n;
  logic       rx_restart, rx_tick;
  logic       commit, ferr_n, perr_n;
  logic [7:0] rx_data_q;
  logic       rx_eff_q, rx_overrun_q, rx_ferr_q;
`ifdef UART_PARITY_EN
  logic       rx_par, rx_par_n;
  logic       rx_perr_q;
`endif

  uart_baud_gen #(.DIV(DIV)) u_rx_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (rx_restart),
    .tick    (rx_tick)
  );

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_tick_cnt_n = rx_tick_cnt;
    rx_bit_idx_n  = rx_bit_idx;
    rx_shreg_n    = rx_shreg;
    rx_wait_hi_n  = rx_wait_hi;
    rx_restart    = 1'b0;
    commit        = 1'b0;
    ferr_n        = 1'b0;
    perr_n        = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_n      = rx_par;
`endif
    case (rx_state)
      RX_IDLE: begin
        // After a framing error the line may still be low; hold off until it returns high.
        if (rx_wait_hi) begin
          if (rx_s) rx_wait_hi_n = 1'b0;
        end else if (!rx_s) begin
          rx_restart    = 1'b1;
          rx_tick_cnt_n = '0;
          rx_state_n    = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_tick_cnt_n = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              rx_state_n    = RX_DATA;
              rx_tick_cnt_n = '0;
              rx_bit_idx_n  = '0;
            end else begin
              rx_state_n = RX_IDLE;
            end
          end
        end
      end
      default: begin
        if (rx_tick) begin
          rx_tick_cnt_n = rx_tick_cnt + 4'd1;
          if (rx_tick_cnt == TICK_LAST) begin
            case (rx_state)
              RX_DATA: begin
                rx_shreg_n   = {rx_s, rx_shreg[7:1]};
                rx_bit_idx_n = rx_bit_idx + 3'd1;
                if (rx_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  rx_state_n = RX_PARITY;
`else
                  rx_state_n = RX_STOP;
`endif
                end
              end
`ifdef UART_PARITY_EN
              RX_PARITY: begin
                rx_par_n   = rx_s;
                rx_state_n = RX_STOP;
              end
`endif
              default: begin
                rx_state_n   = RX_IDLE;
                ferr_n       = !rx_s;
                rx_wait_hi_n = !rx_s;
`ifdef UART_PARITY_EN
                perr_n       = rx_par ^ (^rx_shreg);
`endif
                commit       = rx_s && !perr_n;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_idx  <= '0;
      rx_shreg    <= '0;
      rx_wait_hi  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par      <= 1'b0;
`endif
    end else begin
      rx_state    <= rx_state_n;
      rx_tick_cnt <= rx_tick_cnt_n;
      rx_bit_idx  <= rx_bit_idx_n;
      rx_shreg    <= rx_shreg_n;
      rx_wait_hi  <= rx_wait_hi_n;
`ifdef UART_PARITY_EN
      rx_par      <= rx_par_n;
`endif
    end
  end

  // A commit in the same cycle as rx_read wins, so the new byte is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q    <= 8'h00;
      rx_eff_q     <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_ferr_q <= ferr_n;
`ifdef UART_PARITY_EN
      rx_perr_q <= perr_n;
`endif
      if (commit && (!rx_eff_q || bus.rx_read)) begin
        rx_data_q <= rx_shreg;
        rx_eff_q  <= 1'b1;
      end else if (bus.rx_read) begin
        rx_eff_q  <= 1'b0;
      end
      if (bus.rx_read) begin
        rx_overrun_q <= 1'b0;
      end else if (commit && rx_eff_q) begin
        rx_overrun_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_eff     = rx_eff_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.rx_ferr    = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign bus.rx_perr    = rx_perr_q;
`endif

endmodule
